// File: rtl/sm_display_scheduler.sv
// sm_display_scheduler: time-shares one multiplexed common-anode 7-segment
// display between NSRC 32-bit requesters. The block scans the digits, blanks
// the display between digits and picks the nibble for an external hex decoder.
// It selects the shown source by round-robin dwell or by manual switch, and
// only at frame boundaries.
// Optional feature: define SM_DISPLAY_LZS_EN to enable leading-zero suppression.
module sm_display_scheduler #(
    parameter int NSRC         = 2,
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int HOLD_FRAMES  = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*32-1:0]   src_data_i,
    input  logic [NSRC-1:0]      src_valid_i,
    input  logic                 auto_mode_i,
    input  logic [2:0]           sel_manual_i,
    input  logic                 freeze_i,
    output logic [3:0]           digit_nibble_o,
    output logic [DIGITS-1:0]    anodes_o,
    output logic                 dp_n_o,
    output logic [2:0]           cur_src_o,
    output logic                 frame_start_o
);

    localparam int SLOT_W = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int DIG_W  = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int FRM_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [SLOT_W-1:0] slot_cnt_q,  slot_cnt_d;
    logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]        cur_src_q,   cur_src_d;
    logic [31:0]       snapshot_q,  snapshot_d;
    logic              dark_q,      dark_d;
    logic [3:0]        nibble_d;
    logic [DIGITS-1:0] anodes_d;
    logic              dp_n_d;
    logic [0:0]        slot_state;
    logic [DIGITS-1:0] lit_mask;
    logic              slot_wrap;
    logic              frame_wrap;
`ifdef SM_DISPLAY_LZS_EN
    logic [DIGITS-1:0] lz_mask_q, lz_mask_d;
`endif

    // Word of requester idx; idx is always kept below NSRC.
    function automatic logic [31:0] pick_word(input logic [NSRC*32-1:0] data,
                                              input logic [2:0] idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(idx) == i) w = data[32*i +: 32];
        end
        return w;
    endfunction

    // First valid requester above cur (mod NSRC); cur itself if no other is valid.
    function automatic logic [2:0] next_valid(input logic [2:0] cur,
                                              input logic [NSRC-1:0] valid);
        logic [2:0] nxt;
        logic       found;
        int         idx;
        nxt   = cur;
        found = 1'b0;
        for (int k = 1; k < NSRC; k++) begin
            idx = (int'(cur) + k) % NSRC;
            if (!found && valid[idx]) begin
                nxt   = 3'(idx);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

`ifdef SM_DISPLAY_LZS_EN
    // Lit digits: digit 0 plus every digit up to the most significant nonzero nibble.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [31:0] word);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = DIGITS'(1);
        seen = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            seen = seen | (|word[4*d +: 4]);
            m[d] = seen;
        end
        return m;
    endfunction
`endif

    // Next-state logic: scan counters, frame-boundary source/snapshot update, output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        slot_wrap   = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
        frame_wrap  = slot_wrap && (digit_idx_q == DIG_W'(DIGITS - 1));
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            digit_idx_d = frame_wrap ? '0 : digit_idx_q + DIG_W'(1);
        end

        frame_cnt_d = frame_cnt_q;
        cur_src_d   = cur_src_q;
        snapshot_d  = snapshot_q;
        dark_d      = dark_q;
`ifdef SM_DISPLAY_LZS_EN
        lz_mask_d   = lz_mask_q;
`endif

        if (frame_wrap && !freeze_i) begin
            if (auto_mode_i) begin
                if (frame_cnt_q == FRM_W'(HOLD_FRAMES - 1)) begin
                    frame_cnt_d = '0;
                    cur_src_d   = next_valid(cur_src_q, src_valid_i);
                end else begin
                    frame_cnt_d = frame_cnt_q + FRM_W'(1);
                end
                dark_d     = (src_valid_i == '0);
                snapshot_d = dark_d ? 32'h0 : pick_word(src_data_i, cur_src_d);
            end else begin
                frame_cnt_d = '0;
                if (int'(sel_manual_i) < NSRC) cur_src_d = sel_manual_i;
                dark_d     = 1'b0;
                snapshot_d = pick_word(src_data_i, cur_src_d);
            end
`ifdef SM_DISPLAY_LZS_EN
            lz_mask_d = lz_mask(snapshot_d);
`endif
        end

`ifdef SM_DISPLAY_LZS_EN
        lit_mask = lz_mask_d;
`else
        lit_mask = '1;
`endif

        // Outputs are decoded from next-state values so the registered
        // outputs line up with the counters they describe.
        slot_state = (int'(slot_cnt_d) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;
        anodes_d   = '1;
        if (slot_state == ST_SHOW && !dark_d && lit_mask[digit_idx_d]) begin
            anodes_d[digit_idx_d] = 1'b0;
        end
        nibble_d = snapshot_d[4*int'(digit_idx_d) +: 4];
        dp_n_d   = !(slot_state == ST_SHOW && int'(digit_idx_d) == int'(cur_src_d));
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q     <= '0;
            digit_idx_q    <= '0;
            frame_cnt_q    <= '0;
            cur_src_q      <= '0;
            snapshot_q     <= '0;
            dark_q         <= 1'b0;
            digit_nibble_o <= '0;
            anodes_o       <= '1;
            dp_n_o         <= 1'b1;
            frame_start_o  <= 1'b0;
`ifdef SM_DISPLAY_LZS_EN
            lz_mask_q      <= DIGITS'(1);
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            slot_cnt_q     <= slot_cnt_d;
            digit_idx_q    <= digit_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            cur_src_q      <= cur_src_d;
            snapshot_q     <= snapshot_d;
            dark_q         <= dark_d;
            digit_nibble_o <= nibble_d;
            anodes_o       <= anodes_d;
            dp_n_o         <= dp_n_d;
            frame_start_o  <= frame_wrap;
`ifdef SM_DISPLAY_LZS_EN
            lz_mask_q      <= lz_mask_d;
`endif
        end
    end

    assign cur_src_o = cur_src_q;

endmodule

// File: tb/tb_sm_display_scheduler.sv
// Testbench for sm_display_scheduler (NSRC=2, DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1, HOLD_FRAMES=2). One frame is 16 cycles. Each vector is
// applied just before a frame boundary, and the whole following frame is checked.
module tb_sm_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic [63:0] src_data;
    logic [1:0]  src_valid;
    logic        auto_mode;
    logic [2:0]  sel_manual;
    logic        freeze;
    logic [3:0]  digit_nibble;
    logic [3:0]  anodes;
    logic        dp_n;
    logic [2:0]  cur_src;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SM_DISPLAY_LZS_EN
    localparam logic [3:0] LIT_12   = 4'b0011;
    localparam logic [3:0] LIT_ZERO = 4'b0001;
`else
    localparam logic [3:0] LIT_12   = 4'b1111;
    localparam logic [3:0] LIT_ZERO = 4'b1111;
`endif

    typedef struct {
        logic        auto_m;
        logic [2:0]  sel;
        logic [1:0]  valid;
        logic        frz;
        logic [31:0] src0;
        logic [31:0] src1;
        logic        mid_en;    // change src0 to mid_src0 during digit 2
        logic [31:0] mid_src0;
        logic [2:0]  exp_src;
        logic [15:0] exp_nib;   // digit d expects exp_nib[4d+3:4d]
        logic [3:0]  exp_lit;   // digit d lit during SHOW when exp_lit[d]
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    sm_display_scheduler #(
        .NSRC(2), .DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HOLD_FRAMES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_data_i    (src_data),
        .src_valid_i   (src_valid),
        .auto_mode_i   (auto_mode),
        .sel_manual_i  (sel_manual),
        .freeze_i      (freeze),
        .digit_nibble_o(digit_nibble),
        .anodes_o      (anodes),
        .dp_n_o        (dp_n),
        .cur_src_o     (cur_src),
        .frame_start_o (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t        v;
        logic [3:0]  one;
        logic [3:0]  exp_an;
        string       tag;

        //                auto sel   valid  frz  src0          src1          mid   mid_src0  src   nib       lit
        vecs[0]  = '{1'b0, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[1]  = '{1'b0, 3'd1, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd1, 16'h1234, 4'b1111};
        vecs[2]  = '{1'b0, 3'd5, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd1, 16'h1234, 4'b1111};
        vecs[3]  = '{1'b0, 3'd0, 2'b00, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[4]  = '{1'b0, 3'd0, 2'b11, 1'b0, 32'h0000_0012, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h0012, LIT_12};
        vecs[5]  = '{1'b0, 3'd0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h0000, LIT_ZERO};
        vecs[6]  = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[7]  = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd1, 16'h1234, 4'b1111};
        vecs[8]  = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd1, 16'h1234, 4'b1111};
        vecs[9]  = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[10] = '{1'b1, 3'd0, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[11] = '{1'b1, 3'd0, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[12] = '{1'b1, 3'd0, 2'b00, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h0000, 4'b0000};
        vecs[13] = '{1'b1, 3'd0, 2'b00, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h0000, 4'b0000};
        vecs[14] = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'hABCD, 4'b1111};
        vecs[15] = '{1'b1, 3'd0, 2'b01, 1'b0, 32'h0000_1111, 32'h0000_1234, 1'b1, 32'h0000_2222, 3'd0, 16'h1111, 4'b1111};
        vecs[16] = '{1'b1, 3'd0, 2'b01, 1'b0, 32'h0000_2222, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h2222, 4'b1111};
        vecs[17] = '{1'b1, 3'd0, 2'b01, 1'b0, 32'h0000_1111, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h1111, 4'b1111};
        vecs[18] = '{1'b1, 3'd0, 2'b11, 1'b1, 32'h0000_3333, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h1111, 4'b1111};
        vecs[19] = '{1'b1, 3'd0, 2'b11, 1'b1, 32'h0000_3333, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h1111, 4'b1111};
        vecs[20] = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_3333, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 16'h3333, 4'b1111};
        vecs[21] = '{1'b1, 3'd0, 2'b11, 1'b0, 32'h0000_3333, 32'h0000_1234, 1'b0, 32'h0, 3'd1, 16'h1234, 4'b1111};

        // NOTE: the bench drives inputs with blocking assignments on the falling edge.
        rst_n      = 1'b0;
        auto_mode  = 1'b0;
        sel_manual = 3'd0;
        src_valid  = 2'b11;
        freeze     = 1'b0;
        src_data   = {32'h0000_1234, 32'h0000_ABCD};
        one        = 4'b0001;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst anodes", 32'(anodes), 32'hF);
        check("rst nibble", 32'(digit_nibble), 32'h0);
        check("rst dp_n", 32'(dp_n), 32'h1);
        check("rst cur_src", 32'(cur_src), 32'h0);
        check("rst frame_start", 32'(frame_start), 32'h0);

        // Release: cycle 0 is BLANK, cycles 1..3 show digit 0, cycle 4 blanks again.
        rst_n = 1'b1;
        check("c0 anodes", 32'(anodes), 32'hF);
        tick();
        check("c1 anodes", 32'(anodes), 32'hE);
        check("c1 nibble", 32'(digit_nibble), 32'h0);
        check("c1 dp_n", 32'(dp_n), 32'h0);
        check("c1 frame_start", 32'(frame_start), 32'h0);
        tick();
        check("c2 anodes", 32'(anodes), 32'hE);
        tick();
        check("c3 anodes", 32'(anodes), 32'hE);
        tick();
        check("c4 anodes", 32'(anodes), 32'hF);
        repeat (11) tick();

        // Each vector: inputs applied in cycle 15, then the next frame is checked.
        for (int r = 0; r < NVEC; r++) begin
            v          = vecs[r];
            auto_mode  = v.auto_m;
            sel_manual = v.sel;
            src_valid  = v.valid;
            freeze     = v.frz;
            src_data   = {v.src1, v.src0};
            tick();
            tag = $sformatf("v%0d boundary", r);
            check({tag, " frame_start"}, 32'(frame_start), 32'h1);
            check({tag, " anodes"}, 32'(anodes), 32'hF);
            check({tag, " cur_src"}, 32'(cur_src), 32'(v.exp_src));
            check({tag, " nibble"}, 32'(digit_nibble), 32'(v.exp_nib[3:0]));
            for (int d = 0; d < 4; d++) begin
                tick();
                tag    = $sformatf("v%0d digit%0d", r, d);
                exp_an = v.exp_lit[d] ? ~(one << d) : 4'hF;
                check({tag, " anodes"}, 32'(anodes), 32'(exp_an));
                check({tag, " nibble"}, 32'(digit_nibble), 32'(v.exp_nib[4*d +: 4]));
                check({tag, " dp_n"}, 32'(dp_n), (d == int'(v.exp_src)) ? 32'h0 : 32'h1);
                check({tag, " frame_start"}, 32'(frame_start), 32'h0);
                if (v.mid_en && d == 2) src_data = {v.src1, v.mid_src0};
                tick();
                tick();
                if (d < 3) begin
                    tick();
                    check({tag, " next blank"}, 32'(anodes), 32'hF);
                end
            end
        end

        // Asynchronous reset mid-slot while digit 3 of source 1 is lit.
        #2 rst_n = 1'b0;
        #1;
        check("async rst anodes", 32'(anodes), 32'hF);
        check("async rst cur_src", 32'(cur_src), 32'h0);
        check("async rst nibble", 32'(digit_nibble), 32'h0);
        check("async rst dp_n", 32'(dp_n), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
